// File: rtl/sap_datapath_if.sv
// Sequencer/RAM-facing signal bundle of the SAP execution datapath.
// The master side drives the control word and RAM read data; the datapath is the slave.
interface sap_datapath_if;
  logic [14:0] ctrl;
  logic [3:0]  opcode;
  logic [3:0]  ram_addr;
  logic [7:0]  ram_rdata;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        carry;
  logic        zero;
  logic        halted;
  logic        bus_conflict;
  logic [7:0]  bus_dbg;

  modport master (
    output ctrl, ram_rdata,
    input  opcode, ram_addr, ram_wdata, ram_we, out_data, out_valid,
           carry, zero, halted, bus_conflict, bus_dbg
  );

  modport slave (
    input  ctrl, ram_rdata,
    output opcode, ram_addr, ram_wdata, ram_we, out_data, out_valid,
           carry, zero, halted, bus_conflict, bus_dbg
  );
endinterface

// File: rtl/sap_datapath.sv
// SAP execution datapath: shared OR-bus, PC, MAR, IR, A/B, add/sub ALU and output register.
// Control word changes on negedge; all state updates on posedge.
module sap_datapath #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input logic clk,
   input logic resetn,
   sap_datapath_if.slave dp
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] mar_addr;
   logic [DATA_W-1:0] mar_data;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              carry;
   logic              zero;
   logic              bus_conflict;
   logic              ir_seen;

   logic [DATA_W-1:0] bus;
   logic [DATA_W-1:0] alu;
   logic              alu_c;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] b_op;
   logic [2:0]        drv_cnt;

   // Control word decode; active-low fields are inverted here so everything below is active-high.
   logic pc_inc, drv_pc, pc_load, mar_addr_load, mar_mem_load;
   logic drv_ram, ir_load, drv_ir, a_load, drv_a, sub, drv_alu, b_load, out_load;

   assign pc_inc        = dp.ctrl[14];
   assign drv_pc        = dp.ctrl[13];
   assign pc_load       = dp.ctrl[12];
   assign mar_addr_load = ~dp.ctrl[11];
   assign mar_mem_load  = ~dp.ctrl[10];
   assign drv_ram       = ~dp.ctrl[9];
   assign ir_load       = ~dp.ctrl[7];
   assign drv_ir        = ~dp.ctrl[6];
   assign a_load        = ~dp.ctrl[5];
   assign drv_a         = dp.ctrl[4];
   assign sub           = dp.ctrl[3];
   assign drv_alu       = dp.ctrl[2];
   assign b_load        = ~dp.ctrl[1];
   assign out_load      = ~dp.ctrl[0];

   always_comb begin
      b_op  = sub ? ~b : b;
      sum   = {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub};
      alu   = sum[DATA_W-1:0];
      alu_c = sum[DATA_W];
   end

   // Wired-OR bus: overlapping drivers merge bitwise and are flagged separately.
   always_comb begin
      bus = '0;
      if (drv_pc)  bus = bus | {{(DATA_W-ADDR_W){1'b0}}, pc};
      if (drv_ram) bus = bus | dp.ram_rdata;
      if (drv_ir)  bus = bus | {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
      if (drv_a)   bus = bus | a;
      if (drv_alu) bus = bus | alu;
      drv_cnt = {2'b00, drv_pc} + {2'b00, drv_ram} + {2'b00, drv_ir}
              + {2'b00, drv_a} + {2'b00, drv_alu};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc           <= '0;
         mar_addr     <= '0;
         mar_data     <= '0;
         ir           <= '0;
         a            <= '0;
         b            <= '0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         carry        <= 1'b0;
         zero         <= 1'b0;
         bus_conflict <= 1'b0;
         ir_seen      <= 1'b0;
      end else begin
         if (pc_load)     pc <= bus[ADDR_W-1:0];
         else if (pc_inc) pc <= pc + 1'b1;
         if (mar_addr_load) mar_addr <= bus[ADDR_W-1:0];
         if (mar_mem_load)  mar_data <= bus;
         if (ir_load) begin
            ir      <= bus;
            ir_seen <= 1'b1;
         end
         if (a_load) begin
            a <= bus;
            // Flags only track arithmetic results written back into A.
            if (drv_alu) begin
               carry <= alu_c;
               zero  <= (alu == '0);
            end
         end
         if (b_load)   b <= bus;
         if (out_load) out_data <= bus;
         out_valid <= out_load;
         if (drv_cnt > 3'd1) bus_conflict <= 1'b1;
      end
   end

   assign dp.opcode       = ir[DATA_W-1:DATA_W-4];
   assign dp.ram_addr     = mar_addr;
   assign dp.ram_wdata    = mar_data;
   assign dp.ram_we       = ~dp.ctrl[8];
   assign dp.out_data     = out_data;
   assign dp.out_valid    = out_valid;
   assign dp.carry        = carry;
   assign dp.zero         = zero;
   assign dp.halted       = ir_seen & (ir[DATA_W-1:DATA_W-4] == 4'd0);
   assign dp.bus_conflict = bus_conflict;
   assign dp.bus_dbg      = bus;

endmodule
